mic_capture_sequencer: RTL

MIC_CAPTURE_SEQUENCER -- requirements
Module: mic_capture_sequencer

---
 rtl/sesenta_pkg.sv | 14 +
 rtl/rise_detect.sv | 25 ++
 rtl/mic_capture_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sesenta_pkg.sv
// Shared types and constants for the microphone capture path.
// Holds the sequencer state encoding and the word-to-byte address shift.
package sesenta_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam int BYTE_SHIFT = 2;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector for a slow level input.
// Both stages reset high so a level held through reset never fires.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic start_d;
  logic start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_d <= 1'b1;
      start_q <= 1'b1;
    end else begin
      start_d <= d;
      start_q <= start_d;
    end
  end

  assign rise = start_d & ~start_q;

endmodule

// File: rtl/mic_capture_sequencer.sv
// Sequences PDM mic warm-up and frame capture into per-channel BRAM.
// Writes are registered one cycle after sample_valid.
module mic_capture_sequencer
  import sesenta_pkg::*;
#(
  parameter int ADDR_WIDTH   = 14,
  parameter int WARMUP_EDGES = 2400
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  continuous,
  input  logic [ADDR_WIDTH-1:0] frame_len,
  input  logic                  m_clk_rising,
  input  logic                  sample_valid,
  output logic                  mic_rst,
  output logic [31:0]           addr,
  output logic [3:0]            wen,
  output logic                  busy,
  output logic                  done,
  output logic                  half_irq,
  output logic                  full_irq,
  output logic [ADDR_WIDTH:0]   wr_count
);

  localparam int WCW = (WARMUP_EDGES > 1) ? $clog2(WARMUP_EDGES) : 1;

  state_t                state;
  state_t                state_n;
  logic                  start_rise;
  logic [WCW-1:0]        warm_cnt;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH:0]   frame_l;
  logic [ADDR_WIDTH:0]   flen_in;
  logic [ADDR_WIDTH:0]   wr_next;
  logic                  last_edge;
  logic                  write;
  logic                  hit_full;
  logic                  hit_half;
  logic                  arm;

  rise_detect u_start_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (start),
    .rise (start_rise)
  );

  assign flen_in   = (frame_len == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}}
                                       : {1'b0, frame_len};
  assign wr_next   = wr_count + 1'b1;
  assign last_edge = (state == S_WARMUP) && m_clk_rising &&
                     (warm_cnt == WCW'(WARMUP_EDGES - 1));
  assign write     = (state == S_CAPTURE) && sample_valid && !abort;
  assign hit_full  = write && (wr_next == frame_l);
  assign hit_half  = write && (wr_next == {1'b0, frame_l[ADDR_WIDTH:1]});
  assign arm       = !abort && start_rise &&
                     ((state == S_IDLE) || (state == S_DONE));

  assign mic_rst = (state == S_IDLE) || (state == S_DONE);
  assign busy    = (state == S_WARMUP) || (state == S_CAPTURE);
  assign done    = (state == S_DONE);

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: if (start_rise) state_n = S_WARMUP;
        S_WARMUP:       if (last_edge) state_n = S_CAPTURE;
        S_CAPTURE:      if (hit_full && !continuous) state_n = S_DONE;
        default:        state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      wen      <= 4'h0;
      half_irq <= 1'b0;
      full_irq <= 1'b0;
      wr_count <= '0;
      word_idx <= '0;
      warm_cnt <= '0;
      frame_l  <= '0;
    end else begin
      wen      <= write ? 4'hF : 4'h0;
      half_irq <= hit_half;
      full_irq <= hit_full;
      if (arm) begin
        word_idx <= '0;
        wr_count <= '0;
        warm_cnt <= '0;
        frame_l  <= flen_in;
      end
      if ((state == S_WARMUP) && m_clk_rising) begin
        warm_cnt <= warm_cnt + 1'b1;
      end
      if (write) begin
        addr <= 32'(word_idx) << BYTE_SHIFT;
        // Ring mode wraps in the same write so the next sample is not lost
        if (hit_full && continuous) begin
          word_idx <= '0;
          wr_count <= '0;
        end else begin
          word_idx <= word_idx + 1'b1;
          wr_count <= wr_next;
        end
      end
    end
  end

endmodule
